// File: rtl/cfu_cmd_driver_if.sv
// ---------------------------------------------------------------------------
// cfu_cmd_driver_if
//
// The CFU command/response bus between an initiator and a CFU responder.
//
// Signals:
//   cmd_valid                initiator -> responder, command valid
//   cmd_ready                responder -> initiator, command accepted
//   cmd_payload_function_id  initiator -> responder, 10-bit function id
//   cmd_payload_inputs_0/1   initiator -> responder, 32-bit operands
//   rsp_valid                responder -> initiator, response valid
//   rsp_ready                initiator -> responder, response accepted
//   rsp_payload_outputs_0    responder -> initiator, 32-bit result
//
// Modports: master = initiator (the command driver), slave = responder.
// ---------------------------------------------------------------------------
interface cfu_cmd_driver_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  cmd_payload_function_id;
  logic [31:0] cmd_payload_inputs_0;
  logic [31:0] cmd_payload_inputs_1;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_payload_outputs_0;

  modport master (
    output cmd_valid,
    output cmd_payload_function_id,
    output cmd_payload_inputs_0,
    output cmd_payload_inputs_1,
    output rsp_ready,
    input  cmd_ready,
    input  rsp_valid,
    input  rsp_payload_outputs_0
  );

  modport slave (
    input  cmd_valid,
    input  cmd_payload_function_id,
    input  cmd_payload_inputs_0,
    input  cmd_payload_inputs_1,
    input  rsp_ready,
    output cmd_ready,
    output rsp_valid,
    output rsp_payload_outputs_0
  );
endinterface

// File: rtl/cfu_cmd_driver.sv
// ---------------------------------------------------------------------------
// cfu_cmd_driver
//
// Initiator end of the CFU command/response bus. Takes a job (function id +
// operand count), pulls one operand pair per command from the operand
// stream, issues the command, waits for its response and forwards the
// response to the result stream (or drops it when the job asks to discard).
// Exactly one command is outstanding at a time, so results come back in
// issue order.
//
// Ports:
//   clk, reset           clock (rising edge), asynchronous active-low reset
//   job_*                job request: valid/ready, funct, count, discard
//   op_*                 operand stream: valid/ready, data0/data1
//   cfu                  CFU bus (master side)
//   res_*                result stream: valid/ready, data, last
//   busy                 job in progress (state != IDLE)
//   done                 one-cycle pulse at job end (normal or aborted)
//   err                  sticky response-timeout flag, cleared by next job
//
// Every ready/valid is decoded from the state register alone, so no input
// reaches a handshake output combinationally.
// ---------------------------------------------------------------------------
module cfu_cmd_driver #(
  parameter int COUNT_W = 16,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               reset,

  input  logic               job_valid,
  output logic               job_ready,
  input  logic [9:0]         job_funct,
  input  logic [COUNT_W-1:0] job_count,
  input  logic               job_discard,

  input  logic               op_valid,
  output logic               op_ready,
  input  logic [31:0]        op_data0,
  input  logic [31:0]        op_data1,

  cfu_cmd_driver_if.master   cfu,

  output logic               res_valid,
  input  logic               res_ready,
  output logic [31:0]        res_data,
  output logic               res_last,

  output logic               busy,
  output logic               done,
  output logic               err
);

  // Wide enough for any TIMEOUT in 1..2^16-1.
  localparam int TIMER_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    ISSUE,
    WAIT_RSP,
    DELIVER
  } state_t;

  state_t               state_reg,    state_next;
  logic [9:0]           funct_reg,    funct_next;
  logic [COUNT_W-1:0]   remain_reg,   remain_next;
  logic                 discard_reg,  discard_next;
  logic [31:0]          in0_reg,      in0_next;
  logic [31:0]          in1_reg,      in1_next;
  logic [31:0]          res_data_reg, res_data_next;
  logic                 res_last_reg, res_last_next;
  logic                 done_reg,     done_next;
  logic                 err_reg,      err_next;
  logic [TIMER_W-1:0]   timer_reg,    timer_next;

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      funct_reg    <= '0;
      remain_reg   <= '0;
      discard_reg  <= 1'b0;
      in0_reg      <= '0;
      in1_reg      <= '0;
      res_data_reg <= '0;
      res_last_reg <= 1'b0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
      timer_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      funct_reg    <= funct_next;
      remain_reg   <= remain_next;
      discard_reg  <= discard_next;
      in0_reg      <= in0_next;
      in1_reg      <= in1_next;
      res_data_reg <= res_data_next;
      res_last_reg <= res_last_next;
      done_reg     <= done_next;
      err_reg      <= err_next;
      timer_reg    <= timer_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and datapath update
  // -------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    funct_next    = funct_reg;
    remain_next   = remain_reg;
    discard_next  = discard_reg;
    in0_next      = in0_reg;
    in1_next      = in1_reg;
    res_data_next = res_data_reg;
    res_last_next = res_last_reg;
    done_next     = 1'b0;
    err_next      = err_reg;
    timer_next    = timer_reg;

    case (state_reg)
      IDLE: begin
        // Responses arriving here are strays (e.g. late after a timeout);
        // rsp_ready is high so they are drained and dropped.
        if (job_valid) begin
          funct_next   = job_funct;
          remain_next  = job_count;
          discard_next = job_discard;
          err_next     = 1'b0;
          if (job_count == '0) begin
            done_next = 1'b1;
          end else begin
            state_next = FETCH;
          end
        end
      end

      FETCH: begin
        if (op_valid) begin
          in0_next   = op_data0;
          in1_next   = op_data1;
          state_next = ISSUE;
        end
      end

      ISSUE: begin
        if (cfu.cmd_ready) begin
          timer_next = '0;
          state_next = WAIT_RSP;
        end
      end

      WAIT_RSP: begin
        if (cfu.rsp_valid) begin
          res_data_next = cfu.rsp_payload_outputs_0;
          remain_next   = remain_reg - COUNT_W'(1);
          res_last_next = (remain_reg == COUNT_W'(1));
          if (!discard_reg) begin
            state_next = DELIVER;
          end else if (remain_reg == COUNT_W'(1)) begin
            done_next  = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = FETCH;
          end
        end else if (timer_reg == TIMER_W'(TIMEOUT - 1)) begin
          // The TIMEOUT-th silent cycle: abandon the job. Operands not yet
          // pulled stay in the upstream stream.
          err_next   = 1'b1;
          done_next  = 1'b1;
          state_next = IDLE;
        end else begin
          timer_next = timer_reg + TIMER_W'(1);
        end
      end

      DELIVER: begin
        if (res_ready) begin
          if (res_last_reg) begin
            done_next  = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = FETCH;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Outputs: state decodes and register copies only
  // -------------------------------------------------------------------------
  assign job_ready = (state_reg == IDLE);
  assign op_ready  = (state_reg == FETCH);
  assign res_valid = (state_reg == DELIVER);
  assign busy      = (state_reg != IDLE);
  assign done      = done_reg;
  assign err       = err_reg;
  assign res_data  = res_data_reg;
  assign res_last  = res_last_reg;

  assign cfu.cmd_valid               = (state_reg == ISSUE);
  assign cfu.rsp_ready               = (state_reg == IDLE) || (state_reg == WAIT_RSP);
  assign cfu.cmd_payload_function_id = funct_reg;
  assign cfu.cmd_payload_inputs_0    = in0_reg;
  assign cfu.cmd_payload_inputs_1    = in1_reg;

endmodule

// File: doc/cfu_cmd_driver.md
# cfu_cmd_driver

Initiator end of the CFU command/response bus. Accepts a job (function id + operand count), pulls operand pairs from a stream, issues one CFU command per pair, collects each response, and forwards it to a result stream. Sits between a local sequencer or DMA and any CFU responder (MAC, conv1d front-end), so kernels can run without per-word CPU instructions.

## Interface

- COUNT_W, 16, width of job operand count
- TIMEOUT, 255, max cycles to wait for a response before aborting the job (1..2^16-1)

- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- job_valid  in  1  job request
- job_ready  out  1  high only in IDLE
- job_funct  in  10  function id driven on every command of the job
- job_count  in  COUNT_W  number of commands to issue
- job_discard  in  1  1 = consume responses without emitting results
- op_valid / op_ready  in / out  1 / 1  operand stream handshake
- op_data0, op_data1  in  32 / 32  operand pair
- cmd_valid  out  1  command valid
- cmd_ready  in  1  responder accepts command
- cmd_payload_function_id  out  10  latched job_funct
- cmd_payload_inputs_0, cmd_payload_inputs_1  out  32 / 32  latched operands
- rsp_valid  in  1  response valid
- rsp_ready  out  1  driver accepts response
- rsp_payload_outputs_0  in  32  response data
- res_valid / res_ready  out / in  1 / 1  result stream handshake
- res_data  out  32  captured response
- res_last  out  1  marks result of final command of the job
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at job end (normal or aborted)
- err  out  1  sticky timeout flag, cleared on next job acceptance

## Operation

- States: IDLE, FETCH, ISSUE, WAIT_RSP, DELIVER.
- IDLE: job_ready=1, rsp_ready=1 (drains stray responses, discarded). On job_valid&&job_ready: latch funct, count, discard; clear err. count==0 -> pulse done, stay IDLE. Else -> FETCH.
- FETCH: op_ready=1. On op_valid: latch op_data0/1 into cmd payload -> ISSUE.
- ISSUE: cmd_valid=1, payload stable until handshake; rsp_ready=0. On cmd_ready -> WAIT_RSP, timeout counter cleared.
- WAIT_RSP: rsp_ready=1. On rsp_valid: capture rsp_payload_outputs_0 into res_data, decrement remaining count. If discard: last -> done pulse, IDLE; else -> FETCH. If not discard -> DELIVER, res_last = (remaining becomes 0).
- DELIVER: res_valid=1, res_data/res_last stable. On res_ready: last -> done pulse, IDLE; else -> FETCH.
- Timeout: in WAIT_RSP, counter increments each cycle without rsp_valid; reaching TIMEOUT -> err=1, done pulse, IDLE. Unconsumed operands remain in the upstream stream. A late response is drained in IDLE.
- Exactly one command outstanding at any time; no reordering.
- Remaining count is COUNT_W bits, loaded from job_count, never wraps (job ends at 0).

## Timing

- Reset values: job_ready=1 (state IDLE), op_ready=0, cmd_valid=0, rsp_ready=1, res_valid=0, res_last=0, busy=0, done=0, err=0, payload and res_data registers 0. Handshakes while reset is low are ignored.
- All outputs are registered or decoded from state only; no combinational path from any input to any ready/valid.
- Job accepted at edge E: FETCH from E. Operand accepted at edge F: cmd_valid high from F.
- With a responder answering one cycle after command acceptance and res_ready held high: 4 cycles per command (FETCH, ISSUE, WAIT_RSP, DELIVER); 3 cycles with discard.
- done asserts the cycle after the final res handshake (or response capture when discarding, or timeout expiry); busy drops on that same cycle.
- rsp_valid seen in ISSUE or FETCH is not accepted (rsp_ready=0).
- Reset asserted mid-job: immediate return to IDLE, all valids low, job lost, err cleared.

## Test plan

- MAC responder (funct7=0 accumulates sum of (a+128)*b per byte): job funct=0, count=2, ops (0x00000000,0x01010101) twice -> res_data 0x200 then 0x400, res_last on second, done once, 8 cycles total.
- count=0 job -> no cmd_valid, done pulses one cycle after acceptance, busy never high.
- discard=1, count=3, funct=1<<3 (clear) -> 3 commands issued, res_valid never high, done after third response.
- Responder stalls cmd_ready 5 cycles and res_ready low 3 cycles -> payload and res_data held stable, no duplicate or lost command, correct results.
- Responder never answers, TIMEOUT=255 -> err=1 and done exactly 255 cycles after command acceptance; late rsp_valid drained in IDLE; next job clears err.
- Assert reset during WAIT_RSP -> all outputs return to reset values asynchronously; new job after release runs normally.
